// File: rtl/uart_rx_os.sv
// uart_rx_os -- oversampling UART receiver.
// Synchronises RxD, votes 2-of-3 samples around mid-bit and reports
// framing, parity and break conditions alongside a one-cycle rx_valid.
// Optional feature macro: UART_RX_PARITY_EN. When defined, frames carry a
// parity bit (even/odd per PARITY_ODD). When undefined, parity_err is tied low.
module uart_rx_os #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = 4;
    localparam int MID     = OVERSAMPLE / 2;

    // Reject parameter sets the sampling scheme cannot support.
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_os: OVERSAMPLE must be even and at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_os: DATA_BITS must be in 5..9");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx_os: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    logic                   sync1;
    logic                   rxs;
    logic [DW-1:0]          div_cnt;
    logic [SW-1:0]          scnt;
    logic [BW-1:0]          bcnt;
    logic                   samp0;
    logic                   samp1;
    logic [DATA_BITS-1:0]   shreg;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad;
`endif

    logic                   tick;
    logic                   start_edge;
    logic                   at_vote;
    logic                   at_wrap;
    logic                   voted;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= RxD;
            rxs   <= sync1;
        end
    end

    // Decode the tick, the sample-point strobes and the 2-of-3 vote.
    always_comb begin
        // NOTE: each signal gets a default first so no path leaves it unassigned (no latch).
        tick       = 1'b0;
        start_edge = 1'b0;
        at_vote    = 1'b0;
        at_wrap    = 1'b0;
        voted      = 1'b1;
        tick       = (div_cnt == DW'(DIV - 1));
        start_edge = (state == S_IDLE) && !rxs;
        at_vote    = tick && (scnt == SW'(MID + 1));
        at_wrap    = tick && (scnt == SW'(OVERSAMPLE - 1));
        voted      = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    end

    // Tick divider, re-phased to the start edge so samples land mid-bit.
    always_ff @(posedge clk) begin
        if (reset || start_edge) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Receive FSM: sample counting, bit assembly and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            scnt       <= '0;
            bcnt       <= '0;
            samp0      <= 1'b1;
            samp1      <= 1'b1;
            // NOTE: the shift register is small control state, so it is reset like any other flop.
            shreg      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;

            if (tick && state != S_IDLE && state != S_BREAK) begin
                if (scnt == SW'(MID - 1)) samp0 <= rxs;
                if (scnt == SW'(MID))     samp1 <= rxs;
                scnt <= at_wrap ? '0 : scnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        busy  <= 1'b1;
                        scnt  <= '0;
                        bcnt  <= '0;
                    end
                end

                S_START: begin
                    if (at_vote && voted) begin
                        // Start bit did not hold low: treat as a glitch.
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (at_wrap) begin
                        state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (at_vote) begin
                        shreg <= {voted, shreg[DATA_BITS-1:1]};
                        bcnt  <= bcnt + 1'b1;
                    end
                    if (at_wrap && bcnt == BW'(DATA_BITS)) begin
`ifdef UART_RX_PARITY_EN
                        state <= S_PARITY;
`else
                        state <= S_STOP;
`endif
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (at_vote) begin
                        par_bad <= voted ^ (^shreg) ^ PARITY_ODD[0];
                    end
                    if (at_wrap) begin
                        state <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    // Finish at the stop-bit vote so a following start edge is not missed.
                    if (at_vote) begin
                        rx_data   <= shreg;
                        rx_valid  <= 1'b1;
                        frame_err <= ~voted;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
`else
                        parity_err <= 1'b0;
`endif
                        if (voted) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_BREAK;
                            break_det <= 1'b1;
                        end
                    end
                end

                S_BREAK: begin
                    if (rxs) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        break_det <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os -- self-checking bench for uart_rx_os.
// DIV=1 (16 clocks per bit). Expected words, error flags and strobe timing
// come from a frame-level model; a monitor records every rx_valid strobe.
module tb_uart_rx_os;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 16;
    localparam int MID      = OS / 2;
    localparam int ODD      = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS    = 1;
`else
    localparam int PBITS    = 0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rxd   = 1'b1;
    logic       rxd7  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, break_det, busy;
    logic [6:0] rx_data7;
    logic       rx_valid7, frame_err7, parity_err7, break_det7, busy7;

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_BITS(8), .PARITY_ODD(ODD)) dut (
        .clk(clk), .reset(reset), .RxD(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .parity_err(parity_err), .break_det(break_det), .busy(busy)
    );

    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_BITS(7), .PARITY_ODD(ODD)) dut7 (
        .clk(clk), .reset(reset), .RxD(rxd7),
        .rx_data(rx_data7), .rx_valid(rx_valid7), .frame_err(frame_err7),
        .parity_err(parity_err7), .break_det(break_det7), .busy(busy7)
    );

    typedef struct {
        logic [8:0] data;
        logic       fe;
        logic       pe;
        longint     cyc;
    } frame_t;

    frame_t cap_q[$];
    frame_t cap7_q[$];
    longint cyc         = 0;
    int     checks      = 0;
    int     errors      = 0;
    int     strobe_viol = 0;
    logic   prev_v      = 1'b0;
    logic   prev_v7     = 1'b0;
    bit     use7        = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the cycle it appeared; flag any strobe wider than one clock.
    always @(negedge clk) begin
        if (rx_valid)  cap_q.push_back('{data: {1'b0, rx_data}, fe: frame_err, pe: parity_err, cyc: cyc});
        if (rx_valid7) cap7_q.push_back('{data: {2'b00, rx_data7}, fe: frame_err7, pe: parity_err7, cyc: cyc});
        if ((rx_valid && prev_v) || (rx_valid7 && prev_v7)) strobe_viol++;
        prev_v  = rx_valid;
        prev_v7 = rx_valid7;
    end

    task automatic tick_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v);
        if (use7) rxd7 = v;
        else      rxd  = v;
    endtask

    // Correct parity bit for the low w bits of d.
    function automatic logic good_par(input logic [8:0] d, input int w);
        logic [8:0] m;
        m = d & ((9'h1 << w) - 9'h1);
        return (^m) ^ (ODD != 0);
    endfunction

    // Frame-level model: what the receiver must report for one transmitted frame.
    function automatic frame_t model(input logic [8:0] d, input int w, input logic par,
                                     input logic stop, input longint c0);
        frame_t f;
        f.data = d & ((9'h1 << w) - 9'h1);
        f.fe   = !stop;
        f.pe   = (PBITS == 1) ? (par != good_par(d, w)) : 1'b0;
        f.cyc  = c0 + longint'((1 + w + PBITS) * OS + (MID + 1) + 3);
        return f;
    endfunction

    // Transmit one frame; optionally invert one clock at mid-bit of data bit glitch_bit.
    // The line is left at the stop-bit level.
    task automatic send_frame(input logic [8:0] d, input int w, input logic par,
                              input logic stop, input int glitch_bit, output longint c0);
        c0 = cyc;
        drive(1'b0);
        tick_clk(OS);
        for (int i = 0; i < w; i++) begin
            drive(d[i]);
            if (i == glitch_bit) begin
                tick_clk(MID);
                drive(!d[i]);
                tick_clk(1);
                drive(d[i]);
                tick_clk(OS - MID - 1);
            end else begin
                tick_clk(OS);
            end
        end
        if (PBITS == 1) begin
            drive(par);
            tick_clk(OS);
        end
        drive(stop);
        tick_clk(OS);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rxd   = 1'b1;
        tick_clk(3);
        checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        checks++; if (break_det !== 1'b0) begin errors++; $display("FAIL reset_break_det: got %b expected 0", break_det); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        tick_clk(5);
    endtask

    task automatic test_clean_frames();
        frame_t ex[2];
        longint c0;
        cap_q.delete();
        send_frame(9'h041, 8, good_par(9'h041, 8), 1'b1, -1, c0);
        ex[0] = model(9'h041, 8, good_par(9'h041, 8), 1'b1, c0);
        send_frame(9'h00D, 8, good_par(9'h00D, 8), 1'b1, -1, c0);
        ex[1] = model(9'h00D, 8, good_par(9'h00D, 8), 1'b1, c0);
        drive(1'b1);
        tick_clk(20);
        checks++;
        if (cap_q.size() != 2) begin errors++; $display("FAIL clean_count: got %0d expected 2", cap_q.size()); end
        for (int i = 0; i < 2 && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i].data !== ex[i].data) begin errors++; $display("FAIL clean_data[%0d]: got %h expected %h", i, cap_q[i].data, ex[i].data); end
            checks++; if (cap_q[i].fe !== ex[i].fe) begin errors++; $display("FAIL clean_frame_err[%0d]: got %b expected %b", i, cap_q[i].fe, ex[i].fe); end
            checks++; if (cap_q[i].pe !== ex[i].pe) begin errors++; $display("FAIL clean_parity_err[%0d]: got %b expected %b", i, cap_q[i].pe, ex[i].pe); end
            checks++;
            if (cap_q[i].cyc < ex[i].cyc - 1 || cap_q[i].cyc > ex[i].cyc + 1) begin
                errors++; $display("FAIL clean_latency[%0d]: got cycle %0d expected %0d +/-1", i, cap_q[i].cyc, ex[i].cyc);
            end
        end
    endtask

    task automatic test_random_frames();
        frame_t     ex_q[$];
        longint     c0;
        logic [8:0] d;
        logic       stop, par;
        int         glitch, gap;
        cap_q.delete();
        for (int n = 0; n < 8; n++) begin
            d      = 9'($urandom_range(0, 255));
            stop   = ($urandom_range(0, 3) != 0);
            par    = good_par(d, 8) ^ 1'($urandom_range(0, 1));
            glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            send_frame(d, 8, par, stop, glitch, c0);
            ex_q.push_back(model(d, 8, par, stop, c0));
            gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            drive(1'b1);
            tick_clk(gap * OS);
        end
        drive(1'b1);
        tick_clk(20);
        checks++;
        if (cap_q.size() != ex_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", cap_q.size(), ex_q.size()); end
        for (int i = 0; i < ex_q.size() && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i].data !== ex_q[i].data) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, cap_q[i].data, ex_q[i].data); end
            checks++; if (cap_q[i].fe !== ex_q[i].fe) begin errors++; $display("FAIL rand_frame_err[%0d]: got %b expected %b", i, cap_q[i].fe, ex_q[i].fe); end
            checks++; if (cap_q[i].pe !== ex_q[i].pe) begin errors++; $display("FAIL rand_parity_err[%0d]: got %b expected %b", i, cap_q[i].pe, ex_q[i].pe); end
            checks++;
            if (cap_q[i].cyc < ex_q[i].cyc - 1 || cap_q[i].cyc > ex_q[i].cyc + 1) begin
                errors++; $display("FAIL rand_latency[%0d]: got cycle %0d expected %0d +/-1", i, cap_q[i].cyc, ex_q[i].cyc);
            end
        end
    endtask

    task automatic test_framing_break();
        frame_t ex;
        longint c0;
        cap_q.delete();
        send_frame(9'h055, 8, good_par(9'h055, 8), 1'b0, -1, c0);
        ex = model(9'h055, 8, good_par(9'h055, 8), 1'b0, c0);
        tick_clk(20 * OS);
        checks++; if (break_det !== 1'b1) begin errors++; $display("FAIL break_active: got %b expected 1", break_det); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b expected 1", busy); end
        tick_clk(20 * OS);
        checks++;
        if (cap_q.size() != 1) begin errors++; $display("FAIL break_count: got %0d expected 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            checks++; if (cap_q[0].data !== ex.data) begin errors++; $display("FAIL break_data: got %h expected %h", cap_q[0].data, ex.data); end
            checks++; if (cap_q[0].fe !== ex.fe) begin errors++; $display("FAIL break_frame_err: got %b expected %b", cap_q[0].fe, ex.fe); end
        end
        drive(1'b1);
        tick_clk(6);
        checks++; if (break_det !== 1'b0) begin errors++; $display("FAIL break_release: got %b expected 0", break_det); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_glitch();
        longint c0;
        cap_q.delete();
        drive(1'b0);
        tick_clk(1);
        drive(1'b1);
        tick_clk(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
        tick_clk(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b expected 0", busy); end
        tick_clk(40);
        checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL glitch_no_valid: got %0d strobes expected 0", cap_q.size()); end
        send_frame(9'h0A5, 8, good_par(9'h0A5, 8), 1'b1, 3, c0);
        drive(1'b1);
        tick_clk(20);
        checks++;
        if (cap_q.size() != 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", cap_q.size()); end
        else if (cap_q[0].data !== 9'h0A5) begin errors++; $display("FAIL glitch_data: got %h expected 0a5", cap_q[0].data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        longint c0;
        cap_q.delete();
        send_frame(9'h007, 8, 1'b1, 1'b1, -1, c0);
        drive(1'b1);
        tick_clk(OS);
        send_frame(9'h007, 8, 1'b0, 1'b1, -1, c0);
        drive(1'b1);
        tick_clk(20);
        checks++;
        if (cap_q.size() != 2) begin errors++; $display("FAIL parity_count: got %0d expected 2", cap_q.size()); end
        else begin
            checks++; if (cap_q[0].pe !== 1'b0) begin errors++; $display("FAIL parity_good: got %b expected 0", cap_q[0].pe); end
            checks++; if (cap_q[1].pe !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b expected 1", cap_q[1].pe); end
            checks++; if (cap_q[1].data !== 9'h007) begin errors++; $display("FAIL parity_data: got %h expected 007", cap_q[1].data); end
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        longint     c0;
        d = 8'h3C;
        cap_q.delete();
        drive(1'b0);
        tick_clk(OS);
        for (int i = 0; i < 4; i++) begin
            drive(d[i]);
            tick_clk(OS);
        end
        drive(d[4]);
        tick_clk(MID);
        reset = 1'b1;
        tick_clk(1);
        reset = 1'b0;
        drive(1'b1);
        tick_clk(20 * OS);
        checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL abort_no_valid: got %0d strobes expected 0", cap_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        send_frame(9'h0C3, 8, good_par(9'h0C3, 8), 1'b1, -1, c0);
        drive(1'b1);
        tick_clk(20);
        checks++;
        if (cap_q.size() != 1) begin errors++; $display("FAIL resync_count: got %0d expected 1", cap_q.size()); end
        else if (cap_q[0].data !== 9'h0C3) begin errors++; $display("FAIL resync_data: got %h expected 0c3", cap_q[0].data); end
    endtask

    task automatic test_width();
        frame_t ex;
        longint c0;
        cap7_q.delete();
        use7 = 1'b1;
        send_frame(9'h07F, 7, good_par(9'h07F, 7), 1'b1, -1, c0);
        ex = model(9'h07F, 7, good_par(9'h07F, 7), 1'b1, c0);
        drive(1'b1);
        tick_clk(20);
        use7 = 1'b0;
        checks++;
        if (cap7_q.size() != 1) begin errors++; $display("FAIL width_count: got %0d expected 1", cap7_q.size()); end
        else begin
            checks++; if (cap7_q[0].data !== ex.data) begin errors++; $display("FAIL width_data: got %h expected %h", cap7_q[0].data, ex.data); end
            checks++; if (cap7_q[0].fe !== 1'b0) begin errors++; $display("FAIL width_frame_err: got %b expected 0", cap7_q[0].fe); end
            checks++;
            if (cap7_q[0].cyc < ex.cyc - 1 || cap7_q[0].cyc > ex.cyc + 1) begin
                errors++; $display("FAIL width_latency: got cycle %0d expected %0d +/-1", cap7_q[0].cyc, ex.cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frames();
        test_random_frames();
        test_framing_break();
        test_glitch();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        test_width();
        checks++;
        if (strobe_viol != 0) begin errors++; $display("FAIL strobe_width: got %0d wide strobes expected 0", strobe_viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
